hpdcache_sram_wmask_rmw: RTL
============================

HPDCACHE_SRAM_WMASK_RMW -- requirements
Module: hpdcache_sram_wmask_rmw

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 0, meaning the address width in bits.
REQ-002 The block SHALL have parameter DATA_SIZE, default 0, meaning the word width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_SIZE, meaning the number of words, which SHALL be at most 2**ADDR_SIZE.
REQ-004 The block SHALL have parameter RDATA_REG, default 0, meaning one extra output register stage on the read path when set to 1.
REQ-005 The block SHALL have a single clock and an asynchronous, active-low reset, with ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  request valid.
- we  input  1  1 = write, 0 = read.
- addr  input  ADDR_SIZE  word address.
- wdata  input  DATA_SIZE  write data.
- wmask  input  DATA_SIZE  per-bit write enable.
- ready  output  1  request accepted this cycle when cs=1 and ready=1.
- rvalid  output  1  one-cycle pulse; rdata updated with read result.
- rdata  output  DATA_SIZE  read data, held until the next rvalid.

Function
REQ-006 Storage SHALL be an internal DEPTH x DATA_SIZE single-port array without native bit mask, so at most one array access (read or write) per cycle.
REQ-007 The FSM SHALL have states INIT (macro only), IDLE and RMW; a request SHALL be accepted only in IDLE with cs=1 and ready=1; requests with ready=0 SHALL be dropped, not queued.
REQ-008 Read: the array SHALL be read in the accept cycle; rvalid and rdata SHALL update 1+RDATA_REG cycles after accept.
REQ-009 Full write (wmask all ones): wdata SHALL be written in the accept cycle; FSM stays IDLE; ready stays 1.
REQ-010 Null write (wmask all zeros): no array access; single-cycle completion; array unchanged.
REQ-011 Partial write: addr, wdata and wmask SHALL be latched and the array read in the accept cycle; the FSM enters RMW.
REQ-012 In RMW, ready SHALL be 0 for exactly one cycle and the array SHALL be written with (old & ~wmask) | (wdata & wmask); the FSM then returns to IDLE.
REQ-013 Writes SHALL NOT assert rvalid or change rdata, including the internal RMW read.
REQ-014 Any access with addr >= DEPTH SHALL leave the array unchanged; a read to such an address SHALL return all zeros with normal rvalid timing.
REQ-015 Back-to-back accepted requests SHALL see all prior completed writes; a read accepted immediately after an RMW SHALL return the merged value.

Reset
REQ-016 While rst_n=0: rvalid=0, rdata=0, all RDATA_REG pipeline stages and RMW latches cleared, and FSM in INIT (macro) or IDLE (no macro).
REQ-017 rst_n asserted during RMW SHALL abort the pending write, leaving the target word at its old value; an in-flight read SHALL be discarded with no rvalid.
REQ-018 Array contents SHALL be unaffected by reset except through the init sweep of REQ-019.

Configuration
REQ-019 With HPDCACHE_SRAM_WMASK_INIT_EN defined:
- After reset release, the FSM stays in INIT for exactly DEPTH cycles, writing zero to addresses 0..DEPTH-1 in order with a counter.
- ready=0 while in INIT and during reset.
- ready=1 in the cycle after the last init write.
REQ-020 Without HPDCACHE_SRAM_WMASK_INIT_EN: there is no INIT state or counter, ready=1 during and immediately after reset, and array contents are undefined until written.

Verification
REQ-021 Full write addr=3, wdata=0xA5A5A5A5, then read addr=3 (RDATA_REG=0) -> rvalid 1 cycle after read accept, rdata=0xA5A5A5A5, ready never low.
REQ-022 Partial write addr=3, wdata=0x00FF00FF, wmask=0x0000FFFF on 0xA5A5A5A5 -> ready low 1 cycle; next read returns 0xA5A500FF.
REQ-023 RDATA_REG=1, read accepted cycle N -> rvalid in N+2 only; rdata holds through subsequent writes.
REQ-024 rst_n pulsed low in RMW cycle of partial write to addr=5 holding 0x11111111 -> rvalid=0, rdata=0, and a later read of addr=5 returns 0x11111111.
REQ-025 INIT_EN defined, DEPTH=8 -> ready low 8 cycles after reset release, cs ignored meanwhile, and all addresses read 0; without macro ready=1 in the first cycle.

Source files
------------

// File: rtl/hpdcache_sram_wmask_rmw.sv
// Single-port SRAM wrapper emulating a per-bit write mask by read-modify-write.
// Define HPDCACHE_SRAM_WMASK_INIT_EN to zero-fill the array after every reset release.
module hpdcache_sram_wmask_rmw #(
    parameter int unsigned ADDR_SIZE = 0,
    parameter int unsigned DATA_SIZE = 0,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE,
    parameter int unsigned RDATA_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [DATA_SIZE-1:0] wmask,
    output logic                 ready,
    output logic                 rvalid,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef HPDCACHE_SRAM_WMASK_INIT_EN
    typedef enum logic [1:0] {INIT, IDLE, RMW} state_t;
    localparam state_t RST_STATE = INIT;
`else
    typedef enum logic {IDLE, RMW} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    state_t state_q, state_d;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic                 in_range;
    logic [AW-1:0]        idx;
    logic [DATA_SIZE-1:0] rd_word;

    logic                 rd_acc;
    logic                 rmw_acc;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [DATA_SIZE-1:0] mem_wdat;

    logic [AW-1:0]        rmw_addr;
    logic [DATA_SIZE-1:0] rmw_wdata;
    logic [DATA_SIZE-1:0] rmw_wmask;
    logic [DATA_SIZE-1:0] rmw_old;
    logic                 rmw_in_range;
    logic [DATA_SIZE-1:0] rmw_merged;

    logic                 s1_vld;
    logic [DATA_SIZE-1:0] s1_dat;

    // Out-of-range addresses never touch the array and read back as zero.
    assign in_range   = 32'(addr) < 32'(DEPTH);
    assign idx        = addr[AW-1:0];
    assign rd_word    = in_range ? mem[idx] : '0;
    assign rmw_merged = (rmw_old & ~rmw_wmask) | (rmw_wdata & rmw_wmask);

`ifdef HPDCACHE_SRAM_WMASK_INIT_EN
    localparam logic [AW-1:0] INIT_LAST = AW'(DEPTH - 1);
    logic [AW-1:0] init_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state_q == INIT) begin
            init_cnt <= init_cnt + AW'(1);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        rd_acc    = 1'b0;
        rmw_acc   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdat  = wdata;
        case (state_q)
`ifdef HPDCACHE_SRAM_WMASK_INIT_EN
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt;
                mem_wdat  = '0;
                if (init_cnt == INIT_LAST) begin
                    state_d = IDLE;
                end
            end
`endif
            IDLE: begin
                ready = 1'b1;
                if (cs && rst_n) begin
                    if (!we) begin
                        rd_acc = 1'b1;
                    end else if (&wmask) begin
                        mem_we = in_range;
                    end else if (|wmask) begin
                        rmw_acc = 1'b1;
                        state_d = RMW;
                    end
                end
            end
            RMW: begin
                mem_we    = rmw_in_range;
                mem_waddr = rmw_addr;
                mem_wdat  = rmw_merged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A write is suppressed while reset is held so an aborted RMW leaves the old word.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            s1_vld       <= 1'b0;
            s1_dat       <= '0;
            rmw_addr     <= '0;
            rmw_wdata    <= '0;
            rmw_wmask    <= '0;
            rmw_old      <= '0;
            rmw_in_range <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_vld  <= rd_acc;
            if (rd_acc) begin
                s1_dat <= rd_word;
            end
            if (rmw_acc) begin
                rmw_addr     <= idx;
                rmw_wdata    <= wdata;
                rmw_wmask    <= wmask;
                rmw_old      <= rd_word;
                rmw_in_range <= in_range;
            end
        end
    end

    if (RDATA_REG != 0) begin : g_rdata_reg
        logic                 s2_vld;
        logic [DATA_SIZE-1:0] s2_dat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat <= s1_dat;
                end
            end
        end

        assign rvalid = s2_vld;
        assign rdata  = s2_dat;
    end else begin : g_rdata_direct
        assign rvalid = s1_vld;
        assign rdata  = s1_dat;
    end

endmodule
